axis_slave_rx: RTL and testbench



---
 rtl/axis_slave_rx.sv | 173 +++++++++++++++++
 tb/tb_axis_slave_rx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module      : axis_slave_rx
//  Description : AXI-Stream slave receiver. Accepted beats (tdata, tkeep,
//                tlast, tuser) go into a first-word-fall-through FIFO that is
//                drained through a valid/ready read port. A rotating ready
//                pattern throttles s_tready. The master's stall behaviour is
//                checked: a beat must not change or drop while it is stalled.
//                Beat and packet counters and a mid-packet flag are kept.
//  Ports       : aclk, areset            clock, synchronous active-high reset
//                s_t*                    AXIS slave interface
//                rx_en, bp_pattern       receive enable, ready pattern
//                rd_*                    FIFO head read port
//                level                   FIFO occupancy
//                beat_count, pkt_count   statistics (wrap modulo 2^32)
//                in_packet               set between a non-last and last beat
//                err_stable, err_clear   sticky stability error and its clear
//  Revision    : 1.0  initial release
// ============================================================================
module axis_slave_rx #(
    parameter int DATA_W = 8,
    parameter int USER_W = 1,
    parameter int DEST_W = 1,
    parameter int DEPTH  = 16,
    parameter int PAT_W  = 16
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [DATA_W-1:0]          s_tdata,
    input  logic [DATA_W/8-1:0]        s_tstrb,
    input  logic [DATA_W/8-1:0]        s_tkeep,
    input  logic                       s_tlast,
    input  logic                       s_tid,
    input  logic [DEST_W-1:0]          s_tdest,
    input  logic [USER_W-1:0]          s_tuser,
    input  logic                       rx_en,
    input  logic [PAT_W-1:0]           bp_pattern,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [DATA_W-1:0]          rd_data,
    output logic [DATA_W/8-1:0]        rd_keep,
    output logic                       rd_last,
    output logic [USER_W-1:0]          rd_user,
    output logic [$clog2(DEPTH):0]     level,
    output logic [31:0]                beat_count,
    output logic [31:0]                pkt_count,
    output logic                       in_packet,
    output logic                       err_stable,
    input  logic                       err_clear
);

    localparam int c_kw = DATA_W / 8;
    localparam int c_aw = $clog2(DEPTH);
    // FIFO word: {tuser, tlast, tkeep, tdata}
    localparam int c_fw = USER_W + 1 + c_kw + DATA_W;
    // Stability snapshot: every field the master must hold while stalled
    localparam int c_sw = DATA_W + 2 * c_kw + 2 + DEST_W + USER_W;
    localparam logic [c_aw:0] c_full_lvl = (c_aw + 1)'(DEPTH);

    logic [PAT_W-1:0]  r_pat;
    logic              r_run;       // low in the cycle after reset so s_tready resets to 0
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_level;
    logic [c_fw-1:0]   r_mem [DEPTH];
    logic [31:0]       r_beat_cnt;
    logic [31:0]       r_pkt_cnt;
    logic              r_in_pkt;
    logic              r_err;
    logic              r_prev_stall;
    logic [c_sw-1:0]   r_prev_snap;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [c_fw-1:0]   w_head;
    logic [c_sw-1:0]   w_snap;
    logic              w_violation;

    assign w_full   = (r_level == c_full_lvl);
    assign w_empty  = (r_level == '0);

    // Ready depends only on registered state and rx_en; a pop in the same
    // cycle cannot open room for a push while full.
    assign s_tready = r_run & rx_en & ~w_full & r_pat[0];
    assign w_push   = s_tvalid & s_tready;
    assign rd_valid = ~w_empty;
    assign w_pop    = rd_valid & rd_ready;

    assign w_snap   = {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
    assign w_violation = r_prev_stall & (~s_tvalid | (w_snap != r_prev_snap));

    // Storage has no reset; the head is masked while empty so stale words
    // never appear on the read port.
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_tuser, s_tlast, s_tkeep, s_tdata};
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        rd_data = '0;
        rd_keep = '0;
        rd_last = 1'b0;
        rd_user = '0;
        if (rd_valid) begin
            rd_data = w_head[DATA_W-1:0];
            rd_keep = w_head[DATA_W +: c_kw];
            rd_last = w_head[DATA_W + c_kw];
            rd_user = w_head[c_fw-1 -: USER_W];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_pat        <= bp_pattern;
            r_run        <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_beat_cnt   <= '0;
            r_pkt_cnt    <= '0;
            r_in_pkt     <= 1'b0;
            r_err        <= 1'b0;
            r_prev_stall <= 1'b0;
            r_prev_snap  <= '0;
        end else begin
            r_pat        <= {r_pat[0], r_pat[PAT_W-1:1]};
            r_run        <= 1'b1;
            r_prev_stall <= s_tvalid & ~s_tready;
            r_prev_snap  <= w_snap;

            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_beat_cnt <= r_beat_cnt + 32'd1;
                if (s_tlast) begin
                    r_pkt_cnt <= r_pkt_cnt + 32'd1;
                end
                r_in_pkt <= ~s_tlast;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end

            // A fresh violation takes priority over a clear in the same cycle
            if (w_violation) begin
                r_err <= 1'b1;
            end else if (err_clear) begin
                r_err <= 1'b0;
            end
        end
    end

    assign level      = r_level;
    assign beat_count = r_beat_cnt;
    assign pkt_count  = r_pkt_cnt;
    assign in_packet  = r_in_pkt;
    assign err_stable = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axis_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_slave_rx
//  Description : Directed self-checking bench for axis_slave_rx (DEPTH=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axis_slave_rx;

    localparam int DATA_W = 8;
    localparam int USER_W = 1;
    localparam int DEST_W = 1;
    localparam int DEPTH  = 4;
    localparam int PAT_W  = 16;

    logic              aclk = 1'b0;
    logic              areset;
    logic              s_tvalid;
    logic              s_tready;
    logic [7:0]        s_tdata;
    logic [0:0]        s_tstrb;
    logic [0:0]        s_tkeep;
    logic              s_tlast;
    logic              s_tid;
    logic [0:0]        s_tdest;
    logic [0:0]        s_tuser;
    logic              rx_en;
    logic [15:0]       bp_pattern;
    logic              rd_valid;
    logic              rd_ready;
    logic [7:0]        rd_data;
    logic [0:0]        rd_keep;
    logic              rd_last;
    logic [0:0]        rd_user;
    logic [2:0]        level;
    logic [31:0]       beat_count;
    logic [31:0]       pkt_count;
    logic              in_packet;
    logic              err_stable;
    logic              err_clear;

    int n_vec = 0;
    int n_err = 0;

    axis_slave_rx #(
        .DATA_W (DATA_W),
        .USER_W (USER_W),
        .DEST_W (DEST_W),
        .DEPTH  (DEPTH),
        .PAT_W  (PAT_W)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tdata    (s_tdata),
        .s_tstrb    (s_tstrb),
        .s_tkeep    (s_tkeep),
        .s_tlast    (s_tlast),
        .s_tid      (s_tid),
        .s_tdest    (s_tdest),
        .s_tuser    (s_tuser),
        .rx_en      (rx_en),
        .bp_pattern (bp_pattern),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_keep    (rd_keep),
        .rd_last    (rd_last),
        .rd_user    (rd_user),
        .level      (level),
        .beat_count (beat_count),
        .pkt_count  (pkt_count),
        .in_packet  (in_packet),
        .err_stable (err_stable),
        .err_clear  (err_clear)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Holds reset for three edges; leaves areset high on return
    task automatic do_reset(input logic [15:0] pat);
        areset     = 1'b1;
        bp_pattern = pat;
        rx_en      = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = 8'h00;
        s_tlast    = 1'b0;
        rd_ready   = 1'b0;
        err_clear  = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        int sent;
        int popped;
        int acc;
        int cyc;

        s_tstrb = 1'b1;
        s_tkeep = 1'b1;
        s_tid   = 1'b0;
        s_tdest = 1'b0;
        s_tuser = 1'b0;

        // ---------------- reset ----------------
        do_reset(16'hFFFF);
        #1;
        check("rst_tready",  {63'd0, s_tready}, 64'd0);
        check("rst_rdvalid", {63'd0, rd_valid}, 64'd0);
        check("rst_rddata",  {56'd0, rd_data},  64'd0);
        check("rst_level",   {61'd0, level},    64'd0);
        check("rst_beats",   {32'd0, beat_count}, 64'd0);
        check("rst_pkts",    {32'd0, pkt_count},  64'd0);
        check("rst_inpkt",   {63'd0, in_packet}, 64'd0);
        check("rst_err",     {63'd0, err_stable}, 64'd0);
        areset = 1'b0;
        rx_en  = 1'b1;
        step();
        check("rel_tready", {63'd0, s_tready}, 64'd1);

        // ---------------- single beat ----------------
        s_tvalid = 1'b1;
        s_tdata  = 8'hAA;
        s_tlast  = 1'b1;
        #1;
        check("sb_tready", {63'd0, s_tready}, 64'd1);
        step();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        #1;
        check("sb_rdvalid", {63'd0, rd_valid}, 64'd1);
        check("sb_rddata",  {56'd0, rd_data},  64'hAA);
        check("sb_rdkeep",  {63'd0, rd_keep},  64'd1);
        check("sb_rdlast",  {63'd0, rd_last},  64'd1);
        check("sb_level",   {61'd0, level},    64'd1);
        check("sb_beats",   {32'd0, beat_count}, 64'd1);
        check("sb_pkts",    {32'd0, pkt_count},  64'd1);
        check("sb_inpkt",   {63'd0, in_packet}, 64'd0);
        rd_ready = 1'b1;
        step();
        check("sb_popped", {61'd0, level}, 64'd0);
        step();
        check("sb_empty_pop", {61'd0, level}, 64'd0);
        check("sb_empty_valid", {63'd0, rd_valid}, 64'd0);

        // ---------------- full ----------------
        do_reset(16'hFFFF);
        areset = 1'b0;
        rx_en  = 1'b1;
        step();
        sent = 0;
        for (int i = 0; i < 4; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(sent + 1);
            s_tlast  = 1'b0;
            #1;
            check("full_accept", {63'd0, s_tready}, 64'd1);
            if (s_tready) sent++;
            step();
        end
        s_tdata = 8'(sent + 1);
        for (int i = 0; i < 2; i++) begin
            #1;
            check("full_tready", {63'd0, s_tready}, 64'd0);
            check("full_level",  {61'd0, level},    64'd4);
            step();
        end
        rd_ready = 1'b1;
        popped   = 0;
        cyc      = 0;
        while (popped < 6 && cyc < 40) begin
            s_tvalid = (sent < 6);
            s_tdata  = 8'(sent + 1);
            s_tlast  = (sent == 5);
            #1;
            if (rd_valid) begin
                check("full_order", {56'd0, rd_data}, 64'(popped + 1));
                popped++;
            end
            if (s_tvalid && s_tready) sent++;
            step();
            cyc++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        #1;
        check("full_popped", 64'(popped), 64'd6);
        check("full_beats", {32'd0, beat_count}, 64'd6);
        check("full_pkts",  {32'd0, pkt_count},  64'd1);
        check("full_level0", {61'd0, level}, 64'd0);
        check("full_err",   {63'd0, err_stable}, 64'd0);

        // ---------------- pattern ----------------
        do_reset(16'h5555);
        areset   = 1'b0;
        rx_en    = 1'b1;
        rd_ready = 1'b1;
        s_tvalid = 1'b1;
        step();
        acc = 0;
        for (int k = 0; k < 16; k++) begin
            s_tvalid = (acc < 8);
            s_tdata  = 8'(acc);
            #1;
            check("pat_tready", {63'd0, s_tready}, 64'(k % 2));
            if (s_tvalid && s_tready) acc++;
            step();
        end
        s_tvalid = 1'b0;
        #1;
        check("pat_beats", {32'd0, beat_count}, 64'd8);
        check("pat_err",   {63'd0, err_stable}, 64'd0);

        // ---------------- stability ----------------
        do_reset(16'hFFFF);
        areset   = 1'b0;
        rx_en    = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 8'h11;
        step();
        step();
        s_tdata = 8'h22;
        #1;
        check("stab_pre", {63'd0, err_stable}, 64'd0);
        step();
        check("stab_set", {63'd0, err_stable}, 64'd1);
        step();
        check("stab_sticky", {63'd0, err_stable}, 64'd1);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        #1;
        check("stab_clear", {63'd0, err_stable}, 64'd0);
        s_tdata = 8'h33;
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        s_tdata = 8'h33;
        #1;
        check("stab_win", {63'd0, err_stable}, 64'd1);

        // ---------------- reset mid-packet ----------------
        do_reset(16'hFFFF);
        areset = 1'b0;
        rx_en  = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(8'h40 + i);
            s_tlast  = 1'b0;
            step();
        end
        s_tvalid = 1'b0;
        #1;
        check("mid_inpkt", {63'd0, in_packet}, 64'd1);
        check("mid_level", {61'd0, level},     64'd2);
        rx_en = 1'b0;
        step();
        check("mid_hold_inpkt", {63'd0, in_packet}, 64'd1);
        check("mid_hold_level", {61'd0, level},     64'd2);
        areset = 1'b1;
        step();
        check("mrst_level",   {61'd0, level},      64'd0);
        check("mrst_inpkt",   {63'd0, in_packet},  64'd0);
        check("mrst_beats",   {32'd0, beat_count}, 64'd0);
        check("mrst_pkts",    {32'd0, pkt_count},  64'd0);
        check("mrst_rdvalid", {63'd0, rd_valid},   64'd0);
        check("mrst_tready",  {63'd0, s_tready},   64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
